// File: rtl/add64_seq.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq
// Brief    : Sequences one 64-bit addition as two passes through an external
//            registered 32-bit adder stage (low half, then high half with the
//            low-half carry chained in). Operands and results move over
//            valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module add64_seq #(
    parameter int ADD_LAT = 2            // adder-stage latency in clk edges (1..15)
) (
    input  logic        clk,
    input  logic        rst,
    // operand handshake
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_ci,
    // result handshake
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_co,
    output logic        out_ovf,
    // adder-stage interface
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic [31:0] add_s,
    input  logic        add_co
);

    // Countdown reload value; four bits cover the whole legal latency range.
    localparam logic [3:0] c_LAT = 4'(ADD_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_LO = 2'd1,
        S_WAIT_HI = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a_hi;     // upper operand halves, held until the high issue
    logic [31:0] r_b_hi;
    logic [31:0] r_sum_lo;   // low-half result awaiting the high half

    // Operands are accepted only while idle.
    assign in_ready = (r_state == S_IDLE);

    // Sequencer: issue low half, wait ADD_LAT+1 edges, issue high half with the
    // chained carry, wait again, then present the result until consumed.
    // The adder outputs are only looked at on the cnt==0 edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a_hi    <= '0;
            r_b_hi    <= '0;
            r_sum_lo  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_ci    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_hi  <= in_a[63:32];
                        r_b_hi  <= in_b[63:32];
                        add_a   <= in_a[31:0];
                        add_b   <= in_b[31:0];
                        add_ci  <= in_ci;
                        r_cnt   <= c_LAT;
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_sum_lo <= add_s;
                        add_a    <= r_a_hi;
                        add_b    <= r_b_hi;
                        add_ci   <= add_co;   // carry out of bit 31 feeds the high half
                        r_cnt    <= c_LAT;
                        r_state  <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        out_sum   <= {add_s, r_sum_lo};
                        out_co    <= add_co;
                        // Signed overflow: like-signed operands give an unlike-signed sum.
                        out_ovf   <= (r_a_hi[31] == r_b_hi[31]) && (add_s[31] != r_a_hi[31]);
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add64_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add64_seq
// Brief    : Self-checking bench for add64_seq with a 2-cycle registered
//            32-bit adder stage model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add64_seq;

    localparam int c_LAT = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_ci;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_co;
    logic        out_ovf;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ci;
    logic [31:0] add_s;
    logic        add_co;

    add64_seq #(.ADD_LAT(c_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co)
    );

    // Registered 32-bit adder stage, two register levels deep.
    logic [31:0] r_s1, r_s2;
    logic        r_c1, r_c2;
    always @(posedge clk) begin
        {r_c1, r_s1} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_ci);
        r_s2 <= r_s1;
        r_c2 <= r_c1;
    end
    assign add_s  = r_s2;
    assign add_co = r_c2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [64:0] full;
        exp_t e;
        full  = {1'b0, a} + {1'b0, b} + 65'(ci);
        e.sum = full[63:0];
        e.co  = full[64];
        e.ovf = (a[63] == b[63]) && (full[63] != a[63]);
        return e;
    endfunction

    // Result monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_result", out_valid, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sum", out_sum, mon_e.sum);
                check("co",  out_co,  mon_e.co);
                check("ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present operands when ready; returns the cycle index of the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci,
                        output int t_acc);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            step(1);
            k++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(a, b, ci));
        #1;
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!out_valid && k < 100) begin
            step(1);
            k++;
        end
        check("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || !in_ready) && k < 200) begin
            step(1);
            k++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_sum"},   out_sum,   64'd0);
        check({tag, "_out_co"},    out_co,    1'b0);
        check({tag, "_out_ovf"},   out_ovf,   1'b0);
        check({tag, "_add_a"},     add_a,     32'd0);
        check({tag, "_add_b"},     add_b,     32'd0);
        check({tag, "_add_ci"},    add_ci,    1'b0);
        check({tag, "_in_ready"},  in_ready,  1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, c;
        logic [63:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b1;

        // 1. reset state and basic add with exact latency
        step(3);
        check_zero_outputs("reset");
        rst = 1'b0;
        step(1);
        send(64'd1, 64'd2, 1'b0, t0);
        step(5);
        check("valid_before_t0p6", out_valid, 1'b0);
        step(1);
        check("valid_at_t0p6", out_valid, 1'b1);
        check("basic_sum_direct", out_sum, 64'd3);
        wait_drain();

        // 2. carry crossing from low to high half
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, t0);
        step(3);
        check("hi_issue_add_ci", add_ci, 1'b1);
        check("hi_issue_add_a",  add_a,  32'd0);
        wait_drain();

        // 3. full wrap and signed overflow (positive and negative)
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, t0);
        wait_drain();
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, t0);
        wait_drain();
        send(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, t0);
        wait_drain();

        // 4. backpressure in DONE
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, t0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_a     = 64'hDEAD_BEEF_DEAD_BEEF;
                in_b     = 64'h1111_1111_1111_1111;
                in_valid = 1'b1;
            end
            step(1);
            in_valid = 1'b0;
            check("bp_hold_sum",   out_sum,   64'h2222_2222_2222_2212);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_in_ready",   in_ready,  1'b0);
        end
        out_ready = 1'b1;
        c = cyc;
        send(64'd100, 64'd200, 1'b0, t1);
        check("bp_next_accept_edge", t1, c + 2);
        wait_drain();

        // 5. reset in the middle of an operation
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, t0);
        step(4);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_zero_outputs("midrst");
        step(2);
        rst = 1'b0;
        step(1);
        send(64'd5, 64'd7, 1'b0, t0);
        wait_valid();
        check("midrst_sum_direct", out_sum, 64'd12);
        wait_drain();

        // 6. back-to-back random operands
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            send(ra, rb, 1'($urandom_range(0, 1)), t1);
            if (i > 0) check("b2b_spacing", t1 - t0, 8);
            t0 = t1;
        end
        wait_drain();
        step(10);
        check("sb_empty_end", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
